lane_deserializer16: RTL and testbench

Collects a serial stream of DWIDTH-bit words into one 16-lane parallel frame (`out1`..`out16`) and hands the frame downstream with a valid/ready handshake. It is the producer side of the 16-input summation stage: it builds the parallel operand vector that the adder tree consumes, turning one scalar-per-cycle source (memory read, MAC output) into 16 simultaneous lanes. Short frames, marked with `in_last`, are zero-padded so a downstream sum is unaffected.

---
 rtl/lane_deserializer16.sv | 100 ++++++++++
 tb/tb_lane_deserializer16.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lane_deserializer16.sv
// Serial-to-parallel frame builder: packs DWIDTH-bit words into 16 lanes,
// zero-pads short frames and hands each frame off with valid/ready.
module lane_deserializer16 #(
    parameter int DWIDTH = 32,
    parameter int x      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DWIDTH-1:0] out1,
    output logic [DWIDTH-1:0] out2,
    output logic [DWIDTH-1:0] out3,
    output logic [DWIDTH-1:0] out4,
    output logic [DWIDTH-1:0] out5,
    output logic [DWIDTH-1:0] out6,
    output logic [DWIDTH-1:0] out7,
    output logic [DWIDTH-1:0] out8,
    output logic [DWIDTH-1:0] out9,
    output logic [DWIDTH-1:0] out10,
    output logic [DWIDTH-1:0] out11,
    output logic [DWIDTH-1:0] out12,
    output logic [DWIDTH-1:0] out13,
    output logic [DWIDTH-1:0] out14,
    output logic [DWIDTH-1:0] out15,
    output logic [DWIDTH-1:0] out16,
    output logic [x:0]        out_count,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int LANES = 1 << x;
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    logic [0:0]        state;
    logic [x-1:0]      idx;
    logic [x-1:0]      widx;
    logic [DWIDTH-1:0] lane [LANES];
    logic              accept;
    logic              present;
    logic              done;

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign present   = out_valid && out_ready;
    // A word accepted while a frame is being handed off always starts a new frame.
    assign widx      = out_valid ? '0 : idx;
    assign done      = in_last || (widx == {x{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            out_count <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                if ((x)'(i) == widx) begin
                    lane[i] <= in_data;
                end else if (done && ((x)'(i) > widx)) begin
                    lane[i] <= '0;
                end
            end
            if (done) begin
                state     <= FULL;
                out_count <= {1'b0, widx} + {{x{1'b0}}, 1'b1};
                idx       <= '0;
            end else begin
                state <= FILL;
                idx   <= widx + 1'b1;
            end
        end else if (present) begin
            state <= FILL;
        end
    end

    assign out1  = lane[0];
    assign out2  = lane[1];
    assign out3  = lane[2];
    assign out4  = lane[3];
    assign out5  = lane[4];
    assign out6  = lane[5];
    assign out7  = lane[6];
    assign out8  = lane[7];
    assign out9  = lane[8];
    assign out10 = lane[9];
    assign out11 = lane[10];
    assign out12 = lane[11];
    assign out13 = lane[12];
    assign out14 = lane[13];
    assign out15 = lane[14];
    assign out16 = lane[15];

endmodule

// File: tb/tb_lane_deserializer16.sv
// Bench for lane_deserializer16: directed frames plus a random handshake run,
// with a frame scoreboard checked by an independent output monitor.
module tb_lane_deserializer16;

    typedef struct packed {
        logic [15:0][31:0] l;
        logic [4:0]        n;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] o [16];
    logic [4:0]  out_count;
    logic        out_valid;
    logic        out_ready;

    frame_t      sb [$];
    logic [31:0] cur [16];
    int          cnt = 0;
    int          errors = 0;
    int          checks = 0;
    int          accepted = 0;

    always #5 clk = ~clk;

    lane_deserializer16 #(.DWIDTH(32), .x(4)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready),
        .out1(o[0]), .out2(o[1]), .out3(o[2]), .out4(o[3]),
        .out5(o[4]), .out6(o[5]), .out7(o[6]), .out8(o[7]),
        .out9(o[8]), .out10(o[9]), .out11(o[10]), .out12(o[11]),
        .out13(o[12]), .out14(o[13]), .out15(o[14]), .out16(o[15]),
        .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference frame assembly, fed only with words the handshake accepted.
    task automatic model_accept(input logic [31:0] d, input logic l);
        frame_t f;
        cur[cnt] = d;
        cnt++;
        accepted++;
        if (l || cnt == 16) begin
            for (int i = 0; i < 16; i++) f.l[i] = (i < cnt) ? cur[i] : 32'h0;
            f.n = 5'(cnt);
            sb.push_back(f);
            cnt = 0;
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] d,
                         input logic l, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        if (v && in_ready && !rst) model_accept(d, l);
    endtask

    task automatic check_reset_state(input string tag);
        logic [31:0] any;
        any = 32'h0;
        for (int i = 0; i < 16; i++) any |= o[i];
        chk({tag, "_lanes"}, any, 32'h0);
        chk({tag, "_count"}, 32'(out_count), 32'h0);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    endtask

    initial begin : monitor
        frame_t f;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 32'(out_count), 32'h0);
                end else begin
                    f = sb.pop_front();
                    chk("frame_count", 32'(out_count), 32'(f.n));
                    for (int i = 0; i < 16; i++) chk("frame_lane", o[i], f.l[i]);
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] sum;
        int cyc;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Two back-to-back full frames with the sink always ready.
        for (int w = 1; w <= 32; w++) begin
            cycle(1'b1, 32'(w), 1'b0, 1'b1);
            if (w == 17) begin
                chk("valid_after_16th", 32'(out_valid), 32'h1);
                chk("no_bubble_ready", 32'(in_ready), 32'h1);
            end
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("valid_after_32nd", 32'(out_valid), 32'h1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("valid_one_cycle", 32'(out_valid), 32'h0);

        // Short frame, zero padded.
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        sum = 32'h0;
        for (int i = 0; i < 16; i++) sum += o[i];
        chk("short_valid", 32'(out_valid), 32'h1);
        chk("short_count", 32'(out_count), 32'd3);
        chk("short_sum", sum, 32'h21);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Backpressure on a full frame.
        for (int w = 0; w < 16; w++) cycle(1'b1, 32'h200 + 32'(w), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 32'h77, 1'b0, 1'b0);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_lane1", o[0], 32'h200);
            chk("bp_lane16", o[15], 32'h20F);
        end
        cycle(1'b1, 32'h99, 1'b0, 1'b1);
        cycle(1'b1, 32'h9A, 1'b1, 1'b0);

        // Hand-off and a one-word last frame in the same cycle.
        cycle(1'b1, 32'h55, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("sim_valid", 32'(out_valid), 32'h1);
        chk("sim_lane1", o[0], 32'h55);
        chk("sim_lane2", o[1], 32'h0);
        chk("sim_lane16", o[15], 32'h0);
        chk("sim_count", 32'(out_count), 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Reset in the middle of a frame.
        for (int w = 0; w < 7; w++) cycle(1'b1, 32'h300 + 32'(w), 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        cnt = 0;
        @(posedge clk);
        #1;
        check_reset_state("mid_reset");
        rst = 1'b0;
        for (int w = 0; w < 16; w++) cycle(1'b1, 32'h100 + 32'(w), 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_rst_lane1", o[0], 32'h100);
        chk("post_rst_lane16", o[15], 32'h10F);
        chk("post_rst_count", 32'(out_count), 32'd16);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Random handshake traffic.
        accepted = 0;
        cyc = 0;
        while (accepted < 10000 && cyc < 60000) begin
            cycle($urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("random_words_accepted", 32'(accepted >= 10000), 32'h1);
        if (cnt != 0) begin
            cycle(1'b1, 32'hDEAD, 1'b1, 1'b0);
            while (cnt != 0) cycle(1'b1, 32'hDEAD, 1'b1, 1'b1);
        end
        repeat (8) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
